// File: rtl/gradient_compressor_pkg.sv
// Shared types and helpers for the gradient compressor.
// GRAD_SATURATE_EN selects saturating instead of wrapping sums.
package gradient_compressor_pkg;

  localparam int GC_ADDR_W   = 32;
  localparam int GC_IDX_BITS = 4;
  localparam int GC_TAG_W    = GC_ADDR_W - GC_IDX_BITS - 2;
  localparam int GC_CNT_W    = 4;

  typedef struct packed {
    logic                valid;
    logic [GC_TAG_W-1:0] tag;
    logic signed [31:0]  acc;
    logic [GC_CNT_W-1:0] cnt;
  } cache_entry_t;

  typedef struct packed {
    logic [GC_ADDR_W-1:0] addr;
    logic signed [31:0]   value;
  } push_t;

  // Magnitude in 33 bits so the most negative value is representable.
  function automatic logic [32:0] gc_abs(input logic signed [31:0] v);
    logic [32:0] w;
    w = {v[31], v};
    return v[31] ? (33'd0 - w) : w;
  endfunction

  // Accumulator add: saturating or two's-complement wrap.
  function automatic logic signed [31:0] gc_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
`ifdef GRAD_SATURATE_EN
    if (s[32] != s[31]) begin
      return s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end
`endif
    return s[31:0];
  endfunction

endpackage

// File: rtl/gradient_compressor_top_fifo.sv
// gc_sync_fifo: single-clock FIFO with full/empty/count.
// Read data is the head entry, stable until it is popped.
module gc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/gradient_compressor_top.sv
// Sparse gradient accumulation cache + write-combining buffer + DRAM FIFO.
// Define GRAD_SATURATE_EN for saturating sums (default: wrap).
module gradient_compressor_top
  import gradient_compressor_pkg::*;
#(
  parameter int ADDR_WIDTH      = GC_ADDR_W,
  parameter int GRAD_WIDTH      = 16,
  parameter int INDEX_BITS      = GC_IDX_BITS,
  parameter int NUM_WAYS        = 2,
  parameter int MAX_UPDATES     = 8,
  parameter int THRESHOLD       = 100,
  parameter int SMALL_THRESHOLD = 25,
  parameter int WCB_ENTRIES     = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int BURST_SIZE      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic signed [GRAD_WIDTH-1:0] in_grad,
  output logic                         dram_valid,
  input  logic                         dram_ready,
  output logic [ADDR_WIDTH-1:0]        dram_addr,
  output logic signed [31:0]           dram_value,
  input  logic                         flush,
  output logic                         idle
);

  localparam int SETS   = 1 << INDEX_BITS;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WCNT_W = $clog2(WCB_ENTRIES + 1);
  localparam int BCNT_W = $clog2(BURST_SIZE + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [32:0]         TH_BIG   = 33'(THRESHOLD);
  localparam logic [32:0]         TH_SMALL = 33'(SMALL_THRESHOLD);
  localparam logic [GC_CNT_W-1:0] CNT_MAX  = GC_CNT_W'(MAX_UPDATES);
  localparam logic [WAY_W-1:0]    WAY_LAST = WAY_W'(NUM_WAYS - 1);
  localparam logic [INDEX_BITS-1:0] SET_LAST = INDEX_BITS'(SETS - 1);
  localparam logic [WCNT_W-1:0]   WCB_FULL = WCNT_W'(WCB_ENTRIES);
  localparam logic [WCNT_W-1:0]   WCB_ROOM = WCNT_W'(WCB_ENTRIES - 2);
  localparam logic [BCNT_W-1:0]   BURST_MAX = BCNT_W'(BURST_SIZE);

  cache_entry_t          r_cache [SETS][NUM_WAYS];
  logic [WAY_W-1:0]      r_rr [SETS];
  push_t                 r_wcb [WCB_ENTRIES];
  logic [WCNT_W-1:0]     r_wcb_cnt;
  logic                  r_flushing;
  logic [INDEX_BITS-1:0] r_wset;
  logic [WAY_W-1:0]      r_wway;
  logic [BCNT_W-1:0]     r_burst;

  logic [INDEX_BITS-1:0] w_idx;
  logic [GC_TAG_W-1:0]   w_tag;
  logic signed [31:0]    w_g;
  logic [32:0]           w_abs_g;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_free;
  logic [WAY_W-1:0]      w_free_way;
  logic [WAY_W-1:0]      w_vic_way;
  cache_entry_t          w_hit_e;
  cache_entry_t          w_vic;
  cache_entry_t          w_walk_e;
  logic signed [31:0]    w_sum;
  logic [32:0]           w_abs_sum;
  logic [GC_CNT_W-1:0]   w_cnt1;
  logic                  w_accept;
  logic                  w_walk_step;
  logic                  w_push_v;
  push_t                 w_push;
  logic                  w_wr_en;
  logic [INDEX_BITS-1:0] w_wr_set;
  logic [WAY_W-1:0]      w_wr_way;
  cache_entry_t          w_wr_e;
  logic                  w_rr_adv;
  push_t                 w_wcb_nxt [WCB_ENTRIES];
  logic [WCNT_W-1:0]     w_wcb_nxt_cnt;
  logic                  w_wcb_pop;
  logic                  w_merged;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FCNT_W-1:0]     w_fifo_cnt;
  push_t                 w_fifo_q;
  logic                  w_bubble;
  logic                  w_fire;

  assign w_idx   = in_addr[INDEX_BITS+1:2];
  assign w_tag   = in_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_g     = {{(32-GRAD_WIDTH){in_grad[GRAD_WIDTH-1]}}, in_grad};
  assign w_abs_g = gc_abs(w_g);

  assign in_ready    = !reset && !r_flushing && (r_wcb_cnt <= WCB_ROOM);
  assign w_accept    = in_valid && in_ready;
  assign w_walk_step = r_flushing && (r_wcb_cnt != WCB_FULL);

  // Tag lookup: first matching way and first invalid way in the set.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_cache[w_idx][w].valid &&
          r_cache[w_idx][w].tag == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_free && !r_cache[w_idx][w].valid) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  assign w_vic_way = w_free ? w_free_way : r_rr[w_idx];
  assign w_hit_e   = r_cache[w_idx][w_hit_way];
  assign w_vic     = r_cache[w_idx][w_vic_way];
  assign w_walk_e  = r_cache[r_wset][r_wway];
  assign w_sum     = gc_add(w_hit_e.acc, w_g);
  assign w_abs_sum = gc_abs(w_sum);
  assign w_cnt1    = w_hit_e.cnt + 1'b1;

  // Per-cycle cache action: flush walk step, or one accepted update.
  always_comb begin
    w_push_v = 1'b0;
    w_push   = '0;
    w_wr_en  = 1'b0;
    w_wr_set = w_idx;
    w_wr_way = w_hit_way;
    w_wr_e   = '0;
    w_rr_adv = 1'b0;
    if (w_walk_step) begin
      w_wr_set = r_wset;
      w_wr_way = r_wway;
      if (w_walk_e.valid) begin
        w_push_v     = 1'b1;
        w_push.addr  = {w_walk_e.tag, r_wset, 2'b00};
        w_push.value = w_walk_e.acc;
        w_wr_en      = 1'b1;
      end
    end else if (w_accept) begin
      if (w_abs_g >= TH_BIG) begin
        w_push_v     = 1'b1;
        w_push.addr  = in_addr;
        w_push.value = w_hit ? w_sum : w_g;
        w_wr_en      = w_hit;
      end else if (w_hit) begin
        w_wr_en = 1'b1;
        if (w_abs_sum >= TH_BIG || w_cnt1 == CNT_MAX) begin
          w_push_v     = 1'b1;
          w_push.addr  = in_addr;
          w_push.value = w_sum;
        end else begin
          w_wr_e = '{valid: 1'b1, tag: w_tag, acc: w_sum, cnt: w_cnt1};
        end
      end else if (w_abs_g >= TH_SMALL) begin
        w_wr_en  = 1'b1;
        w_wr_way = w_vic_way;
        w_wr_e   = '{valid: 1'b1, tag: w_tag, acc: w_g,
                     cnt: GC_CNT_W'(1)};
        w_rr_adv = !w_free;
        if (w_vic.valid) begin
          w_push_v     = 1'b1;
          w_push.addr  = {w_vic.tag, w_idx, 2'b00};
          w_push.value = w_vic.acc;
        end
      end
    end
  end

  // Cache array and round-robin victim pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) r_cache[s][w] <= '0;
      end
    end else begin
      if (w_wr_en) r_cache[w_wr_set][w_wr_way] <= w_wr_e;
      if (w_rr_adv) begin
        r_rr[w_idx] <= (r_rr[w_idx] == WAY_LAST) ? '0
                                                 : r_rr[w_idx] + 1'b1;
      end
    end
  end

  // Flush walk: one way per cycle, stalled while the WCB is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flushing <= 1'b0;
      r_wset     <= '0;
      r_wway     <= '0;
    end else if (!r_flushing) begin
      if (flush) begin
        r_flushing <= 1'b1;
        r_wset     <= '0;
        r_wway     <= '0;
      end
    end else if (w_walk_step) begin
      if (r_wway == WAY_LAST) begin
        r_wway <= '0;
        if (r_wset == SET_LAST) r_flushing <= 1'b0;
        else                    r_wset     <= r_wset + 1'b1;
      end else begin
        r_wway <= r_wway + 1'b1;
      end
    end
  end

  assign w_wcb_pop = (r_wcb_cnt != '0) && !w_fifo_full;

  // WCB next state: drain the head, then merge or append the push.
  // Merging is checked after the drain so a departing entry is never hit.
  always_comb begin
    w_wcb_nxt     = r_wcb;
    w_wcb_nxt_cnt = r_wcb_cnt;
    w_merged      = 1'b0;
    if (w_wcb_pop) begin
      for (int i = 0; i < WCB_ENTRIES - 1; i++) w_wcb_nxt[i] = r_wcb[i+1];
      w_wcb_nxt[WCB_ENTRIES-1] = '0;
      w_wcb_nxt_cnt = r_wcb_cnt - 1'b1;
    end
    if (w_push_v) begin
      for (int i = 0; i < WCB_ENTRIES; i++) begin
        if (!w_merged && WCNT_W'(i) < w_wcb_nxt_cnt &&
            w_wcb_nxt[i].addr == w_push.addr) begin
          w_wcb_nxt[i].value = gc_add(w_wcb_nxt[i].value, w_push.value);
          w_merged = 1'b1;
        end
      end
      if (!w_merged) begin
        for (int i = 0; i < WCB_ENTRIES; i++) begin
          if (WCNT_W'(i) == w_wcb_nxt_cnt) w_wcb_nxt[i] = w_push;
        end
        w_wcb_nxt_cnt = w_wcb_nxt_cnt + 1'b1;
      end
    end
  end

  // WCB registers, oldest entry at index 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WCB_ENTRIES; i++) r_wcb[i] <= '0;
      r_wcb_cnt <= '0;
    end else begin
      r_wcb     <= w_wcb_nxt;
      r_wcb_cnt <= w_wcb_nxt_cnt;
    end
  end

  gc_sync_fifo #(
    .WIDTH ($bits(push_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_wr_en   (w_wcb_pop),
    .i_wr_data (r_wcb[0]),
    .i_rd_en   (w_fire),
    .o_rd_data (w_fifo_q),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_cnt)
  );

  assign w_bubble   = (r_burst == BURST_MAX);
  assign dram_valid = !w_fifo_empty && !w_bubble;
  assign w_fire     = dram_valid && dram_ready;
  assign dram_addr  = w_fifo_empty ? '0 : w_fifo_q.addr;
  assign dram_value = w_fifo_empty ? '0 : w_fifo_q.value;

  // Consecutive-beat counter; any idle cycle restarts the burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_burst <= '0;
    else if (w_bubble) r_burst <= '0;
    else if (w_fire)   r_burst <= r_burst + 1'b1;
    else               r_burst <= '0;
  end

  assign idle = !r_flushing && !in_valid &&
                (r_wcb_cnt == '0) && (w_fifo_cnt == '0);

endmodule

// File: tb/tb_gradient_compressor_top.sv
// Directed bench for gradient_compressor_top.
// Expected DRAM writes are hand-computed per step.
module tb_gradient_compressor_top;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_addr = '0;
  logic signed [15:0] in_grad = '0;
  logic               dram_valid;
  logic               dram_ready = 1'b1;
  logic [31:0]        dram_addr;
  logic signed [31:0] dram_value;
  logic               flush = 1'b0;
  logic               idle;

  int total = 0;
  int bad   = 0;
  int rd_i  = 0;
  int run   = 0;
  int maxrun = 0;
  int base;

  logic [31:0]        q_addr [$];
  logic signed [31:0] q_val  [$];

  always #5 clock = ~clock;

  gradient_compressor_top dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_grad    (in_grad),
    .dram_valid (dram_valid),
    .dram_ready (dram_ready),
    .dram_addr  (dram_addr),
    .dram_value (dram_value),
    .flush      (flush),
    .idle       (idle)
  );

  // Beat monitor; inputs change just after posedge, so negedge sees
  // exactly the values the next posedge will accept.
  always @(negedge clock) begin
    if (!reset && dram_valid && dram_ready) begin
      q_addr.push_back(dram_addr);
      q_val.push_back(dram_value);
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input int g);
    bit ok;
    ok = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_grad  = 16'(g);
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("send_accept", longint'(ok), 1);
  endtask

  task automatic pulse_flush();
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
  endtask

  task automatic expect_write(input string tag, input longint a,
                              input longint v);
    chk({tag, "_present"}, longint'(q_addr.size() > rd_i), 1);
    if (q_addr.size() > rd_i) begin
      chk({tag, "_addr"}, longint'(q_addr[rd_i]), a);
      chk({tag, "_val"}, longint'(q_val[rd_i]), v);
      rd_i++;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_dram_valid", longint'(dram_valid), 0);
    chk("rst_dram_addr", longint'(dram_addr), 0);
    chk("rst_dram_value", longint'(dram_value), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_idle", longint'(idle), 1);
    chk("post_rst_ready", longint'(in_ready), 1);

    // Tiny misses are dropped
    base = q_addr.size();
    send(32'h1000, 10);
    send(32'h1010, 15);
    send(32'h1020, 5);
    send(32'h1030, -20);
    send(32'h1040, 24);
    cycles(200);
    chk("tiny_writes", longint'(q_addr.size() - base), 0);

    // Hit accumulation: 30 + 7*10 reaches 100 on the 8th update
    base = q_addr.size();
    send(32'h2000, 30);
    for (int i = 0; i < 7; i++) send(32'h2000, 10);
    cycles(50);
    chk("acc_writes", longint'(q_addr.size() - base), 1);
    expect_write("acc", 'h2000, 100);

    // Direct trigger on large magnitudes
    base = q_addr.size();
    send(32'h3000, 150);
    send(32'h3010, -200);
    cycles(50);
    chk("direct_writes", longint'(q_addr.size() - base), 2);
    expect_write("direct0", 'h3000, 150);
    expect_write("direct1", 'h3010, -200);

    // Allocate then hit crossing threshold
    base = q_addr.size();
    send(32'h4000, 50);
    send(32'h4000, 51);
    cycles(50);
    chk("hit_writes", longint'(q_addr.size() - base), 1);
    expect_write("hit", 'h4000, 101);

    // Inclusive threshold boundaries
    base = q_addr.size();
    send(32'h5000, 24);
    send(32'h5010, 25);
    send(32'h5020, 99);
    send(32'h5030, 100);
    cycles(50);
    chk("bound_writes", longint'(q_addr.size() - base), 1);
    expect_write("bound", 'h5030, 100);

    // Flush pushes the two cached entries
    base = q_addr.size();
    pulse_flush();
    cycles(80);
    chk("flush_writes", longint'(q_addr.size() - base), 2);
    expect_write("flush0", 'h5010, 25);
    expect_write("flush1", 'h5020, 99);
    @(negedge clock);
    chk("flush_idle", longint'(idle), 1);

    // Backpressure: 16 in FIFO + 3 in WCB, then in_ready drops
    base = q_addr.size();
    maxrun = 0;
    @(posedge clock);
    #1;
    dram_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(32'h7000 + 32'(4 * i), 150 + i);
    cycles(3);
    @(negedge clock);
    chk("bp_in_ready_low", longint'(in_ready), 0);
    chk("bp_dram_valid", longint'(dram_valid), 1);
    chk("bp_head_addr", longint'(dram_addr), 'h7000);
    chk("bp_no_writes", longint'(q_addr.size() - base), 0);
    @(posedge clock);
    #1;
    dram_ready = 1'b1;
    send(32'h7000 + 32'(4 * 19), 169);
    cycles(100);
    chk("bp_writes", longint'(q_addr.size() - base), 20);
    for (int i = 0; i < 20; i++) begin
      expect_write("bp", longint'('h7000 + 4 * i), longint'(150 + i));
    end
    chk("bp_burst_len", longint'(maxrun), 4);

    // Eviction: three allocations in set 0, way 0 is the victim
    base = q_addr.size();
    send(32'h6000, 30);
    send(32'h6040, 40);
    send(32'h6080, 50);
    cycles(50);
    chk("evict_writes", longint'(q_addr.size() - base), 1);
    expect_write("evict", 'h6000, 30);
    pulse_flush();
    cycles(80);
    expect_write("evflush0", 'h6080, 50);
    expect_write("evflush1", 'h6040, 40);
    @(negedge clock);
    chk("final_idle", longint'(idle), 1);
    chk("final_writes", longint'(q_addr.size() - rd_i), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
